// File: rtl/ps2_cmd_scheduler_if.sv
// PS/2 transceiver link: write strobe/byte toward the transmitter, busy flag and
// received-byte strobe back from the transceiver.
interface ps2_cmd_scheduler_if;
    logic       check_ps2_beasy;
    logic       write_update;
    logic [7:0] write_data_update;
    logic       read_update;
    logic [7:0] read_date_update;

    // Scheduler side.
    modport master (
        input  check_ps2_beasy,
        input  read_update,
        input  read_date_update,
        output write_update,
        output write_data_update
    );

    // Transceiver side.
    modport slave (
        output check_ps2_beasy,
        output read_update,
        output read_date_update,
        input  write_update,
        input  write_data_update
    );
endinterface

// File: rtl/ps2_cmd_scheduler.sv
// PS/2 host-to-keyboard command scheduler. Queues reset/LED/rate/ID commands, runs
// each one's byte exchange with ACK/RESEND, retry and timeout handling, and forwards
// unsolicited keyboard bytes to the scan-code path.
module ps2_cmd_scheduler #(
    parameter int unsigned TIMEOUT_TICKS = 6000,
    parameter int unsigned RETRY_MAX     = 3
) (
    input  logic                       clk_brain,
    input  logic                       rst,
    input  logic                       tick_300k,
    input  logic                       req_reset,
    input  logic                       req_led,
    input  logic                       req_rate,
    input  logic                       req_id,
    input  logic [2:0]                 led_val,
    input  logic [7:0]                 rate_val,
    ps2_cmd_scheduler_if.master        ps2,
    output logic                       code_new,
    output logic [7:0]                 new_code,
    output logic [15:0]                id_word,
    output logic                       id_valid,
    output logic                       sched_busy,
    output logic                       cmd_err
);
    localparam logic [15:0] TmoTicks   = 16'(TIMEOUT_TICKS);
    localparam logic [7:0]  RetryMax   = 8'(RETRY_MAX);
    localparam logic [1:0]  CmdReset   = 2'd0;
    localparam logic [1:0]  CmdLed     = 2'd1;
    localparam logic [1:0]  CmdRate    = 2'd2;
    localparam logic [1:0]  CmdId      = 2'd3;
    localparam logic [7:0]  ByteAck    = 8'hFA;
    localparam logic [7:0]  ByteResend = 8'hFE;
    localparam logic [7:0]  ByteBatOk  = 8'hAA;
    localparam logic [7:0]  ByteBatErr = 8'hFC;

    typedef enum logic [2:0] {
        StIdle, StSend, StWaitAck, StParam, StWaitData, StDone
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  pend_q, pend_d, pend_clr;
    logic [1:0]  cur_q, cur_d;
    logic [7:0]  byte_q, byte_d;
    logic        param_q, param_d;       // byte_q is the parameter byte, not the opcode
    logic [7:0]  retry_q, retry_d;
    logic [15:0] tmo_q, tmo_d;
    logic        id_half_q, id_half_d;   // first ID byte already captured
    logic [7:0]  id_first_q, id_first_d;
    logic        code_new_q, code_new_d;
    logic [7:0]  new_code_q, new_code_d;
    logic [15:0] id_word_q, id_word_d;
    logic        id_valid_q, id_valid_d;
    logic        cmd_err_q, cmd_err_d;
    logic        fwd, resend, abandon;
    logic        rd;
    logic [7:0]  rd_byte;
    logic        tmo_hit;
    logic        wr_fire;

    assign rd         = ps2.read_update;
    assign rd_byte    = ps2.read_date_update;
    assign tmo_hit    = (tmo_q == TmoTicks);
    assign wr_fire    = (state_q == StSend) && !ps2.check_ps2_beasy;
    assign sched_busy = (state_q != StIdle);

    assign ps2.write_update      = wr_fire;
    assign ps2.write_data_update = wr_fire ? byte_q : 8'h00;

    assign code_new = code_new_q;
    assign new_code = new_code_q;
    assign id_word  = id_word_q;
    assign id_valid = id_valid_q;
    assign cmd_err  = cmd_err_q;

    function automatic logic [7:0] opcode(input logic [1:0] cmd);
        logic [7:0] op;
        case (cmd)
            CmdReset: op = 8'hFF;
            CmdLed:   op = 8'hED;
            CmdRate:  op = 8'hF3;
            default:  op = 8'hF2;
        endcase
        return op;
    endfunction

    // Next-state, pending-set bookkeeping and registered strobe values.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        byte_d     = byte_q;
        param_d    = param_q;
        retry_d    = retry_q;
        id_half_d  = id_half_q;
        id_first_d = id_first_q;
        tmo_d      = (tick_300k && tmo_q != 16'hFFFF) ? tmo_q + 16'd1 : tmo_q;
        pend_clr   = 4'b0000;
        code_new_d = 1'b0;
        new_code_d = new_code_q;
        id_word_d  = id_word_q;
        id_valid_d = 1'b0;
        cmd_err_d  = 1'b0;
        fwd        = 1'b0;
        resend     = 1'b0;
        abandon    = 1'b0;

        unique case (state_q)
            StIdle: begin
                fwd = rd;
                if (pend_q != 4'b0000) begin
                    state_d = StSend;
                    retry_d = 8'd0;
                    param_d = 1'b0;
                    if (pend_q[0])      cur_d = CmdReset;
                    else if (pend_q[1]) cur_d = CmdLed;
                    else if (pend_q[2]) cur_d = CmdRate;
                    else                cur_d = CmdId;
                    byte_d = opcode(cur_d);
                end
            end
            StSend: begin
                fwd = rd;
                if (!ps2.check_ps2_beasy) begin
                    tmo_d   = 16'd0;
                    state_d = StWaitAck;
                end
            end
            StWaitAck: begin
                if (rd && rd_byte == ByteAck) begin
                    if (param_q) begin
                        state_d = StDone;
                    end else if (cur_q == CmdLed || cur_q == CmdRate) begin
                        state_d = StParam;
                    end else begin
                        state_d   = StWaitData;
                        tmo_d     = 16'd0;
                        id_half_d = 1'b0;
                    end
                end else if (rd && rd_byte == ByteResend) begin
                    resend = 1'b1;
                end else if (rd) begin
                    fwd = 1'b1;
                end else if (tmo_hit) begin
                    resend = 1'b1;   // silence counts as a resend request
                end
                if (resend) begin
                    if (retry_q < RetryMax) begin
                        retry_d = retry_q + 8'd1;
                        state_d = StSend;
                    end else begin
                        abandon = 1'b1;
                    end
                end
            end
            StParam: begin
                fwd     = rd;
                byte_d  = (cur_q == CmdLed) ? {5'b00000, led_val} : rate_val;
                param_d = 1'b1;
                retry_d = 8'd0;
                state_d = StSend;
            end
            StWaitData: begin
                // Late ACK/RESEND bytes are not data and are dropped here.
                if (rd) begin
                    if (rd_byte != ByteAck && rd_byte != ByteResend) begin
                        if (cur_q == CmdReset) begin
                            if (rd_byte == ByteBatOk)       state_d = StDone;
                            else if (rd_byte == ByteBatErr) abandon = 1'b1;
                        end else if (!id_half_q) begin
                            id_first_d = rd_byte;
                            id_half_d  = 1'b1;
                            tmo_d      = 16'd0;
                        end else begin
                            id_word_d  = {id_first_q, rd_byte};
                            id_valid_d = 1'b1;
                            state_d    = StDone;
                        end
                    end
                end else if (tmo_hit) begin
                    abandon = 1'b1;
                end
            end
            StDone: begin
                fwd      = rd;
                pend_clr = 4'b0001 << cur_q;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (abandon) begin
            cmd_err_d = 1'b1;
            pend_clr  = 4'b0001 << cur_q;
            state_d   = StIdle;
        end
        if (fwd) begin
            code_new_d = 1'b1;
            new_code_d = rd_byte;
        end
        // Clear before set so a request arriving while its own command finishes re-runs it.
        pend_d = (pend_q & ~pend_clr) | {req_id, req_rate, req_led, req_reset};
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_brain) begin
        if (rst) begin
            state_q    <= StIdle;
            pend_q     <= 4'b0000;
            cur_q      <= 2'd0;
            byte_q     <= 8'h00;
            param_q    <= 1'b0;
            retry_q    <= 8'd0;
            tmo_q      <= 16'd0;
            id_half_q  <= 1'b0;
            id_first_q <= 8'h00;
            code_new_q <= 1'b0;
            new_code_q <= 8'h00;
            id_word_q  <= 16'h0000;
            id_valid_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            cur_q      <= cur_d;
            byte_q     <= byte_d;
            param_q    <= param_d;
            retry_q    <= retry_d;
            tmo_q      <= tmo_d;
            id_half_q  <= id_half_d;
            id_first_q <= id_first_d;
            code_new_q <= code_new_d;
            new_code_q <= new_code_d;
            id_word_q  <= id_word_d;
            id_valid_q <= id_valid_d;
            cmd_err_q  <= cmd_err_d;
        end
    end
endmodule

// File: tb/tb_ps2_cmd_scheduler.sv
// Bench for ps2_cmd_scheduler: a keyboard emulator answers each write, a transaction
// model predicts the written bytes, forwarded codes, ID words and errors, and a
// monitor compares every DUT strobe against those predictions.
module tb_ps2_cmd_scheduler;
    localparam int unsigned Tmo = 24;

    logic        clk_brain = 1'b0;
    logic        rst = 1'b1;
    logic        tick_300k;
    logic        req_reset = 1'b0, req_led = 1'b0, req_rate = 1'b0, req_id = 1'b0;
    logic [2:0]  led_val = 3'b000;
    logic [7:0]  rate_val = 8'h00;
    logic        code_new;
    logic [7:0]  new_code;
    logic [15:0] id_word;
    logic        id_valid;
    logic        sched_busy;
    logic        cmd_err;

    ps2_cmd_scheduler_if ps2 ();

    ps2_cmd_scheduler #(.TIMEOUT_TICKS(Tmo), .RETRY_MAX(3)) dut (
        .clk_brain (clk_brain),
        .rst       (rst),
        .tick_300k (tick_300k),
        .req_reset (req_reset),
        .req_led   (req_led),
        .req_rate  (req_rate),
        .req_id    (req_id),
        .led_val   (led_val),
        .rate_val  (rate_val),
        .ps2       (ps2),
        .code_new  (code_new),
        .new_code  (new_code),
        .id_word   (id_word),
        .id_valid  (id_valid),
        .sched_busy(sched_busy),
        .cmd_err   (cmd_err)
    );

    always #5 clk_brain = ~clk_brain;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  exp_wr[$];
    logic [7:0]  exp_code[$];
    logic [15:0] exp_id[$];
    int          exp_err = 0;
    int          wr_cnt = 0, code_cnt = 0, id_cnt = 0, err_cnt = 0;
    int          script[$];
    logic [7:0]  stray_q[$];
    logic [7:0]  id_q[$];
    bit          rand_mode = 1'b0;
    bit          busy_rand = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Timebase and transmitter-busy generator.
    initial begin
        tick_300k = 1'b0;
        ps2.check_ps2_beasy = 1'b0;
        forever begin
            @(posedge clk_brain);
            #1;
            tick_300k = 1'($urandom_range(0, 1));
            ps2.check_ps2_beasy = busy_rand && ($urandom_range(0, 2) == 0);
        end
    end

    // Compare every DUT strobe against the model's expectation queues.
    always @(negedge clk_brain) begin
        if (!rst) begin
            if (ps2.write_update) begin
                wr_cnt++;
                check("write_while_busy", 32'(ps2.check_ps2_beasy), 32'd0);
                n_cmp++;
                if (exp_wr.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_write: got 0x%0h, expected no write",
                             ps2.write_data_update);
                end else begin
                    n_cmp--;
                    check("write_byte", 32'(ps2.write_data_update), 32'(exp_wr.pop_front()));
                end
            end
            if (code_new) begin
                code_cnt++;
                n_cmp++;
                if (exp_code.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_code_new: got 0x%0h, expected no code", new_code);
                end else begin
                    n_cmp--;
                    check("new_code", 32'(new_code), 32'(exp_code.pop_front()));
                end
            end
            if (id_valid) begin
                id_cnt++;
                n_cmp++;
                if (exp_id.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_id_valid: got 0x%0h, expected no id", id_word);
                end else begin
                    n_cmp--;
                    check("id_word", 32'(id_word), 32'(exp_id.pop_front()));
                end
            end
            if (cmd_err) begin
                err_cnt++;
                n_cmp++;
                if (exp_err == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_cmd_err: got 1, expected 0");
                end else begin
                    exp_err--;
                end
            end
        end
    end

    function automatic int next_resp();
        int r;
        if (script.size() != 0) return script.pop_front();
        if (!rand_mode) return 0;
        r = $urandom_range(0, 99);
        if (r < 55) return 0;
        if (r < 72) return 1;
        if (r < 86) return 2;
        return 3;
    endfunction

    function automatic logic [7:0] stray_byte();
        if (stray_q.size() != 0) return stray_q.pop_front();
        return 8'($urandom_range(0, 8'hF9));
    endfunction

    function automatic logic [7:0] id_byte();
        if (id_q.size() != 0) return id_q.pop_front();
        return 8'($urandom_range(0, 8'hF9));
    endfunction

    task automatic kb_send(input logic [7:0] b);
        ps2.read_update = 1'b1;
        ps2.read_date_update = b;
        @(posedge clk_brain);
        #1;
        ps2.read_update = 1'b0;
        ps2.read_date_update = 8'h00;
    endtask

    task automatic pulse_req(input int cmd);
        case (cmd)
            0:       req_reset = 1'b1;
            1:       req_led = 1'b1;
            2:       req_rate = 1'b1;
            default: req_id = 1'b1;
        endcase
        @(posedge clk_brain);
        #1;
        req_reset = 1'b0; req_led = 1'b0; req_rate = 1'b0; req_id = 1'b0;
    endtask

    task automatic wait_write(output bit ok);
        int start = wr_cnt;
        int n = 0;
        while (wr_cnt == start && n < 600) begin
            @(posedge clk_brain);
            #1;
            n++;
        end
        ok = (wr_cnt != start);
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL write_timeout: got no write in 600 cycles, expected 0x%0h",
                     exp_wr.size() != 0 ? exp_wr[0] : 8'h00);
        end
    endtask

    // Keyboard side of one command: predicts every write and outcome from the
    // protocol rules (ACK advances, RESEND/silence retries up to 3 times).
    task automatic serve_cmd(input int cmd, input logic [7:0] par);
        logic [7:0] opc, b1, b2;
        int nbytes, r, retries;
        bit ok, acked, abandoned;
        opc = (cmd == 0) ? 8'hFF : (cmd == 1) ? 8'hED : (cmd == 2) ? 8'hF3 : 8'hF2;
        nbytes = (cmd == 1 || cmd == 2) ? 2 : 1;
        abandoned = 1'b0;
        for (int k = 0; k < nbytes && !abandoned; k++) begin
            retries = 0;
            acked = 1'b0;
            while (!acked && !abandoned) begin
                exp_wr.push_back((k == 0) ? opc : par);
                wait_write(ok);
                if (!ok) begin
                    abandoned = 1'b1;
                end else begin
                    r = next_resp();
                    if (r == 0) begin
                        kb_send(8'hFA);
                        acked = 1'b1;
                    end else if (r == 2) begin
                        b1 = stray_byte();
                        exp_code.push_back(b1);
                        kb_send(b1);
                        kb_send(8'hFA);
                        acked = 1'b1;
                    end else begin
                        if (r == 1) kb_send(8'hFE);
                        if (retries < 3) retries++;
                        else begin
                            exp_err++;
                            abandoned = 1'b1;
                        end
                    end
                end
            end
        end
        if (!abandoned && (cmd == 0 || cmd == 3)) begin
            r = next_resp();
            if (r == 3) begin
                exp_err++;
            end else if (cmd == 0) begin
                if (r == 2) kb_send(8'hFE);
                if (r == 1) begin
                    exp_err++;
                    kb_send(8'hFC);
                end else begin
                    kb_send(8'hAA);
                end
            end else begin
                if (r != 0) kb_send((r == 1) ? 8'hFE : 8'hFA);
                b1 = id_byte();
                b2 = id_byte();
                kb_send(b1);
                exp_id.push_back({b1, b2});
                kb_send(b2);
            end
        end
    endtask

    task automatic finish_cmd(input string tag);
        int n = 0;
        while (sched_busy && n < 800) begin
            @(posedge clk_brain);
            #1;
            n++;
        end
        check({tag, "_back_to_idle"}, 32'(sched_busy), 32'd0);
        repeat (3) @(posedge clk_brain);
        #1;
        check({tag, "_writes_left"}, 32'(exp_wr.size()), 32'd0);
        check({tag, "_codes_left"}, 32'(exp_code.size()), 32'd0);
        check({tag, "_ids_left"}, 32'(exp_id.size()), 32'd0);
        check({tag, "_errs_left"}, 32'(exp_err), 32'd0);
        exp_wr.delete();
        exp_code.delete();
        exp_id.delete();
        exp_err = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_write_update"}, 32'(ps2.write_update), 32'd0);
        check({tag, "_write_data"}, 32'(ps2.write_data_update), 32'd0);
        check({tag, "_code_new"}, 32'(code_new), 32'd0);
        check({tag, "_new_code"}, 32'(new_code), 32'd0);
        check({tag, "_id_word"}, 32'(id_word), 32'd0);
        check({tag, "_id_valid"}, 32'(id_valid), 32'd0);
        check({tag, "_sched_busy"}, 32'(sched_busy), 32'd0);
        check({tag, "_cmd_err"}, 32'(cmd_err), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0, e0, c0, i0, cmd;
        bit ok;
        logic [7:0] b;
        ps2.read_update = 1'b0;
        ps2.read_date_update = 8'h00;
        repeat (4) @(posedge clk_brain);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk_brain);
        #1;

        // LED 101 with request-to-write latency of 2 cycles, then parameter 05.
        led_val = 3'b101;
        w0 = wr_cnt; e0 = err_cnt;
        exp_wr.push_back(8'hED);
        req_led = 1'b1;
        @(posedge clk_brain);
        #1;
        req_led = 1'b0;
        check("latency_c1_write", 32'(ps2.write_update), 32'd0);
        @(posedge clk_brain);
        #1;
        check("latency_c2_write", 32'(ps2.write_update), 32'd1);
        check("latency_c2_byte", 32'(ps2.write_data_update), 32'hED);
        @(posedge clk_brain);
        #1;
        kb_send(8'hFA);
        exp_wr.push_back(8'h05);
        wait_write(ok);
        kb_send(8'hFA);
        finish_cmd("led");
        check("led_write_count", 32'(wr_cnt - w0), 32'd2);
        check("led_no_err", 32'(err_cnt - e0), 32'd0);

        // Simultaneous rate and LED requests: LED runs first, four writes in all.
        led_val = 3'b010; rate_val = 8'h2B;
        w0 = wr_cnt;
        req_led = 1'b1; req_rate = 1'b1;
        @(posedge clk_brain);
        #1;
        req_led = 1'b0; req_rate = 1'b0;
        serve_cmd(1, 8'h02);
        serve_cmd(2, 8'h2B);
        finish_cmd("dual");
        check("dual_write_count", 32'(wr_cnt - w0), 32'd4);

        // Read ID: FA, AB, 83.
        i0 = id_cnt; c0 = code_cnt;
        id_q.push_back(8'hAB); id_q.push_back(8'h83);
        pulse_req(3);
        serve_cmd(3, 8'h00);
        finish_cmd("id");
        check("id_word_literal", 32'(id_word), 32'hAB83);
        check("id_valid_pulses", 32'(id_cnt - i0), 32'd1);
        check("id_no_code", 32'(code_cnt - c0), 32'd0);

        // Three resends then success.
        led_val = 3'b101;
        w0 = wr_cnt; e0 = err_cnt;
        script = '{1, 1, 1, 0, 0};
        pulse_req(1);
        serve_cmd(1, 8'h05);
        finish_cmd("fe3");
        check("fe3_write_count", 32'(wr_cnt - w0), 32'd5);
        check("fe3_no_err", 32'(err_cnt - e0), 32'd0);

        // Four resends: abandoned after four ED writes.
        w0 = wr_cnt; e0 = err_cnt;
        script = '{1, 1, 1, 1};
        pulse_req(1);
        serve_cmd(1, 8'h05);
        finish_cmd("fe4");
        check("fe4_write_count", 32'(wr_cnt - w0), 32'd4);
        check("fe4_err_pulses", 32'(err_cnt - e0), 32'd1);

        // Stray scan code while waiting for ACK.
        c0 = code_cnt;
        script = '{2, 0};
        stray_q.push_back(8'h1C);
        pulse_req(1);
        serve_cmd(1, 8'h05);
        finish_cmd("stray");
        check("stray_new_code", 32'(new_code), 32'h1C);
        check("stray_code_count", 32'(code_cnt - c0), 32'd1);

        // Reset in the PARAM cycle wipes everything.
        pulse_req(1);
        exp_wr.push_back(8'hED);
        wait_write(ok);
        kb_send(8'hFA);
        rst = 1'b1;
        @(posedge clk_brain);
        #1;
        check_all_zero("midreset");
        @(posedge clk_brain);
        #1;
        rst = 1'b0;
        w0 = wr_cnt;
        repeat (20) @(posedge clk_brain);
        #1;
        check("midreset_no_write", 32'(wr_cnt - w0), 32'd0);
        check("midreset_idle", 32'(sched_busy), 32'd0);
        pulse_req(3);
        serve_cmd(3, 8'h00);
        finish_cmd("after_reset");

        // Randomized commands, responses, stray bytes and transmitter busy.
        rand_mode = 1'b1;
        busy_rand = 1'b1;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                b = 8'($urandom_range(0, 255));
                exp_code.push_back(b);
                kb_send(b);
            end
            cmd = $urandom_range(0, 3);
            led_val = 3'($urandom_range(0, 7));
            rate_val = 8'($urandom_range(0, 255));
            pulse_req(cmd);
            serve_cmd(cmd, (cmd == 1) ? {5'b00000, led_val} : rate_val);
            finish_cmd("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
